// File: rtl/checkpoint_pkg.sv
// Shared types and defaults for the checkpoint sequence monitor.
package checkpoint_pkg;

  localparam int unsigned DEF_CHECK_W       = 16;
  localparam int unsigned DEF_NUM_STAGES    = 4;
  localparam int unsigned DEF_STABLE_CYCLES = 2;
  localparam int unsigned DEF_TMO_W         = 24;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_FIRST = 3'd1,
    ST_TRACK      = 3'd2,
    ST_PASS       = 3'd3,
    ST_FAIL       = 3'd4
  } state_e;

  localparam logic [1:0] FR_NONE    = 2'b00;
  localparam logic [1:0] FR_TIMEOUT = 2'b01;
  localparam logic [1:0] FR_ILLEGAL = 2'b10;

endpackage

// File: rtl/checkpoint_stable_filter.sv
// Two-flop synchroniser followed by a hold-time filter; emits one accept
// pulse each time a new value has been held for STABLE_CYCLES cycles.
module checkpoint_stable_filter #(
  parameter int unsigned CHECK_W       = 16,
  parameter int unsigned STABLE_CYCLES = 2
) (
  input  logic               clock,
  input  logic               resetb,
  input  logic [CHECK_W-1:0] din,
  output logic               acc_valid,
  output logic [CHECK_W-1:0] acc_code
);

  localparam int unsigned        CNT_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(STABLE_CYCLES);

  logic [CHECK_W-1:0] sync1_q;
  logic [CHECK_W-1:0] sync2_q;
  logic [CHECK_W-1:0] cand_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;

  // Metastability guard for the asynchronous bus
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
    end
  end

  // Length of the current run of identical synchronised values, saturating
  always_comb begin
    cnt_d = CNT_W'(1);
    if (sync2_q == cand_q) begin
      cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
    end
  end

  // Track the run and fire once per newly stable value
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      cand_q    <= '0;
      cnt_q     <= '0;
      acc_valid <= 1'b0;
      acc_code  <= '0;
    end else begin
      cand_q    <= sync2_q;
      cnt_q     <= cnt_d;
      acc_valid <= 1'b0;
      if (cnt_d == CNT_MAX && sync2_q != acc_code) begin
        acc_valid <= 1'b1;
        acc_code  <= sync2_q;
      end
    end
  end

endmodule

// File: rtl/checkpoint_seq_monitor.sv
// Watches an asynchronous checkpoint bus and checks that a programmed
// sequence of codes appears in order, with per-stage timeout.
module checkpoint_seq_monitor
  import checkpoint_pkg::*;
#(
  parameter int unsigned CHECK_W       = DEF_CHECK_W,
  parameter int unsigned NUM_STAGES    = DEF_NUM_STAGES,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned TMO_W         = DEF_TMO_W,
  localparam int unsigned IDX_W        = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic               clock,
  input  logic               resetb,
  input  logic [CHECK_W-1:0] checkbits,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic [CHECK_W-1:0] cfg_code,
  input  logic [TMO_W-1:0]   tmo_limit,
  input  logic               strict,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [1:0]         fail_reason,
  output logic [IDX_W-1:0]   stage,
  output logic [CHECK_W-1:0] last_code
);

  localparam int unsigned      TBL_N      = 1 << IDX_W;
  localparam logic [IDX_W-1:0] LAST_STAGE = IDX_W'(NUM_STAGES - 1);

  logic               acc_valid;
  logic [CHECK_W-1:0] acc_code;
  logic [CHECK_W-1:0] code_q [TBL_N];

  state_e             state_q;
  state_e             state_d;
  logic [IDX_W-1:0]   stage_d;
  logic [TMO_W-1:0]   tmo_cnt_q;
  logic [TMO_W-1:0]   tmo_cnt_d;
  logic [1:0]         fail_reason_d;
  logic               tmo_en;
  logic               eval;
  logic               match;
  logic               adv;
  logic               illegal;
  logic               tmo_hit;

  checkpoint_stable_filter #(
    .CHECK_W       (CHECK_W),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_filter (
    .clock     (clock),
    .resetb    (resetb),
    .din       (checkbits),
    .acc_valid (acc_valid),
    .acc_code  (acc_code)
  );

  // Expected-code table, writable at any time
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < int'(TBL_N); i++) code_q[i] <= '0;
    end else if (cfg_we) begin
      code_q[cfg_idx] <= cfg_code;
    end
  end

  // Next-state, stage, timeout and fail-reason decisions
  always_comb begin
    state_d       = state_q;
    stage_d       = stage;
    tmo_cnt_d     = tmo_cnt_q;
    fail_reason_d = fail_reason;
    tmo_en        = (tmo_limit != '0);
    match         = (acc_code == code_q[stage]);
    case (state_q)
      ST_WAIT_FIRST: eval = acc_valid && (acc_code != '0);
      ST_TRACK:      eval = acc_valid;
      default:       eval = 1'b0;
    endcase
    adv     = eval && match;
    illegal = eval && !match && strict && (acc_code != '0) && (acc_code != last_code);
    tmo_hit = tmo_en && (tmo_cnt_q == tmo_limit - TMO_W'(1)) && !adv;

    if (abort) begin
      state_d       = ST_IDLE;
      stage_d       = '0;
      tmo_cnt_d     = '0;
      fail_reason_d = FR_NONE;
    end else begin
      case (state_q)
        ST_IDLE, ST_PASS, ST_FAIL: begin
          if (start) begin
            state_d       = ST_WAIT_FIRST;
            stage_d       = '0;
            tmo_cnt_d     = '0;
            fail_reason_d = FR_NONE;
          end
        end
        ST_WAIT_FIRST, ST_TRACK: begin
          if (eval) state_d = ST_TRACK;
          if (tmo_en && tmo_cnt_q != '1) tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
          if (adv) begin
            tmo_cnt_d = '0;
            if (stage == LAST_STAGE) state_d = ST_PASS;
            else                     stage_d = stage + IDX_W'(1);
          end else if (illegal) begin
            state_d       = ST_FAIL;
            fail_reason_d = FR_ILLEGAL;
          end else if (tmo_hit) begin
            state_d       = ST_FAIL;
            fail_reason_d = FR_TIMEOUT;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and registered status outputs
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q     <= ST_IDLE;
      stage       <= '0;
      tmo_cnt_q   <= '0;
      fail_reason <= FR_NONE;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      last_code   <= '0;
    end else begin
      state_q     <= state_d;
      stage       <= stage_d;
      tmo_cnt_q   <= tmo_cnt_d;
      fail_reason <= fail_reason_d;
      busy        <= (state_d == ST_WAIT_FIRST) || (state_d == ST_TRACK);
      done        <= (state_d == ST_PASS) || (state_d == ST_FAIL);
      pass        <= (state_d == ST_PASS);
      if (acc_valid) last_code <= acc_code;
    end
  end

endmodule

// File: tb/tb_checkpoint_seq_monitor.sv
// Bench for checkpoint_seq_monitor: directed scenarios plus randomised
// code sequences scored against an item-level model of the run rules.
module tb_checkpoint_seq_monitor;

  localparam int unsigned S = 2;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic        resetb;
  logic [15:0] checkbits;
  logic        cfg_we;
  logic [1:0]  cfg_idx;
  logic [15:0] cfg_code;
  logic [23:0] tmo_limit;
  logic        strict, start, abort;
  logic        busy, done, pass;
  logic [1:0]  fail_reason;
  logic [1:0]  stage;
  logic [15:0] last_code;

  logic [31:0] checkbits_b;
  logic        cfg_we_b;
  logic [0:0]  cfg_idx_b;
  logic [31:0] cfg_code_b;
  logic [23:0] tmo_limit_b;
  logic        strict_b, start_b, abort_b;
  logic        busy_b, done_b, pass_b;
  logic [1:0]  fail_reason_b;
  logic [0:0]  stage_b;
  logic [31:0] last_code_b;

  checkpoint_seq_monitor dut (
    .clock(clock), .resetb(resetb), .checkbits(checkbits), .cfg_we(cfg_we),
    .cfg_idx(cfg_idx), .cfg_code(cfg_code), .tmo_limit(tmo_limit), .strict(strict),
    .start(start), .abort(abort), .busy(busy), .done(done), .pass(pass),
    .fail_reason(fail_reason), .stage(stage), .last_code(last_code)
  );

  checkpoint_seq_monitor #(.CHECK_W(32), .NUM_STAGES(1)) dut_b (
    .clock(clock), .resetb(resetb), .checkbits(checkbits_b), .cfg_we(cfg_we_b),
    .cfg_idx(cfg_idx_b), .cfg_code(cfg_code_b), .tmo_limit(tmo_limit_b), .strict(strict_b),
    .start(start_b), .abort(abort_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .fail_reason(fail_reason_b), .stage(stage_b), .last_code(last_code_b)
  );

  typedef struct { logic [15:0] v; int hold; } item_t;
  item_t       items[$];
  logic [15:0] tbl [4];

  int total = 0;
  int bad   = 0;

  logic        e_done, e_pass;
  logic [1:0]  e_fr, e_stage;
  logic [15:0] e_last, v, prevv;
  int          t_acc, t_done, cur, nitems, sel;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_tbl(input logic [1:0] i, input logic [15:0] code);
    cfg_we = 1'b1; cfg_idx = i; cfg_code = code;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic settle_zero();
    checkbits = '0;
    repeat (8) tick();
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic drive(input logic [15:0] val, input int n);
    checkbits = val;
    repeat (n) tick();
  endtask

  // Outcome of a run from the list of held values: a value counts once it is
  // held S cycles and differs from the previously counted one.
  task automatic model_run(input bit strict_m, output logic done_o, output logic pass_o,
                           output logic [1:0] fr_o, output logic [1:0] stage_o,
                           output logic [15:0] last_o);
    int          st;
    logic [15:0] acc;
    st = 0; acc = '0; stage_o = '0; fr_o = 2'b00;
    for (int i = 0; i < items.size(); i++) begin
      int          h;
      logic [15:0] prev;
      h = (i == items.size() - 1) ? 1000 : items[i].hold;
      if (h >= int'(S) && items[i].v != acc) begin
        prev = acc;
        acc  = items[i].v;
        if (st <= 1 && !(st == 0 && acc == 16'h0)) begin
          st = 1;
          if (acc == tbl[stage_o]) begin
            if (stage_o == 2'd3) st = 2;
            else stage_o = stage_o + 2'd1;
          end else if (strict_m && acc != 16'h0 && acc != prev) begin
            st = 3; fr_o = 2'b10;
          end
        end
      end
    end
    done_o = (st >= 2);
    pass_o = (st == 2);
    last_o = acc;
  endtask

  initial begin
    resetb = 1'b0; checkbits = '0; cfg_we = 1'b0; cfg_idx = '0; cfg_code = '0;
    tmo_limit = '0; strict = 1'b0; start = 1'b0; abort = 1'b0;
    checkbits_b = '0; cfg_we_b = 1'b0; cfg_idx_b = '0; cfg_code_b = '0;
    tmo_limit_b = '0; strict_b = 1'b0; start_b = 1'b0; abort_b = 1'b0;
    repeat (3) tick();
    resetb = 1'b1;
    tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_reason", 32'(fail_reason), 0);
    chk("rst_stage", 32'(stage), 0);
    chk("rst_last", 32'(last_code), 0);

    // In-order sequence reaches PASS
    tbl[0] = 16'hAB60; tbl[1] = 16'hAB61; tbl[2] = 16'hAB62; tbl[3] = 16'hAB63;
    for (int k = 0; k < 4; k++) write_tbl(2'(k), tbl[k]);
    strict = 1'b1; tmo_limit = 24'd1000;
    settle_zero(); pulse_start();
    chk("start_busy", 32'(busy), 1);
    for (int k = 0; k < 4; k++) drive(tbl[k], 5);
    repeat (S + 5) tick();
    chk("seq_pass", 32'(pass), 1);
    chk("seq_done", 32'(done), 1);
    chk("seq_busy", 32'(busy), 0);
    chk("seq_stage", 32'(stage), 3);
    chk("seq_last", 32'(last_code), 32'h0000AB63);
    chk("seq_reason", 32'(fail_reason), 0);

    // start and abort together from PASS lands in IDLE
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    chk("startabort_busy", 32'(busy), 0);
    chk("startabort_done", 32'(done), 0);

    // Unexpected code, strict
    settle_zero(); pulse_start();
    drive(16'hAB60, 5); drive(16'h1234, 5);
    repeat (S + 5) tick();
    chk("strict_done", 32'(done), 1);
    chk("strict_pass", 32'(pass), 0);
    chk("strict_reason", 32'(fail_reason), 2);
    chk("strict_last", 32'(last_code), 32'h00001234);

    // Unexpected code, lenient
    strict = 1'b0;
    settle_zero(); pulse_start();
    drive(16'hAB60, 5); drive(16'h1234, 5);
    for (int k = 1; k < 4; k++) drive(tbl[k], 5);
    repeat (S + 5) tick();
    chk("lenient_pass", 32'(pass), 1);
    chk("lenient_reason", 32'(fail_reason), 0);

    // Timeout: FAIL exactly tmo_limit cycles after the advancing accept
    strict = 1'b1; tmo_limit = 24'd50;
    settle_zero(); pulse_start();
    checkbits = 16'hAB60;
    t_acc = -1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (stage == 2'd1) begin t_acc = cyc; break; end
    end
    chk("tmo_accept_seen", 32'(t_acc >= 0), 1);
    t_done = -1;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (done) begin t_done = cyc; break; end
    end
    chk("tmo_latency", 32'(t_done - t_acc), 50);
    chk("tmo_reason", 32'(fail_reason), 1);
    chk("tmo_pass", 32'(pass), 0);

    // Timeout disabled: run stays busy
    tmo_limit = '0;
    settle_zero(); pulse_start();
    drive(16'hAB60, 300);
    chk("notmo_busy", 32'(busy), 1);
    chk("notmo_done", 32'(done), 0);
    chk("notmo_stage", 32'(stage), 1);
    pulse_abort();
    chk("abort_busy", 32'(busy), 0);

    // One-cycle glitch is not accepted
    tmo_limit = 24'd1000;
    settle_zero(); pulse_start();
    drive(16'hAB60, 5); drive(16'hAB61, 1); drive(16'hAB60, 6);
    repeat (S + 3) tick();
    chk("glitch_stage", 32'(stage), 1);
    chk("glitch_busy", 32'(busy), 1);
    chk("glitch_last", 32'(last_code), 32'h0000AB60);
    pulse_abort();

    // Reset in the middle of TRACK
    settle_zero(); pulse_start();
    drive(16'hAB60, 5);
    chk("mid_stage", 32'(stage), 1);
    #2 resetb = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_pass", 32'(pass), 0);
    chk("arst_reason", 32'(fail_reason), 0);
    chk("arst_stage", 32'(stage), 0);
    chk("arst_last", 32'(last_code), 0);
    repeat (2) tick();
    resetb = 1'b1;
    drive(16'hAB61, 10);
    chk("norsm_busy", 32'(busy), 0);
    chk("norsm_stage", 32'(stage), 0);

    // Randomised sequences against the model
    for (int r = 0; r < 12; r++) begin
      strict = 1'($urandom_range(0, 1));
      tmo_limit = '0;
      for (int k = 0; k < 4; k++) begin
        tbl[k] = {4'hA, 2'(k), 10'($urandom)};
        write_tbl(2'(k), tbl[k]);
      end
      items.delete(); cur = 0; prevv = '0;
      nitems = $urandom_range(4, 10);
      for (int j = 0; j < nitems; j++) begin
        item_t it;
        do begin
          sel = $urandom_range(0, 99);
          if (sel < 55)      v = tbl[cur];
          else if (sel < 80) v = {4'h1, 12'($urandom)};
          else if (sel < 90) v = tbl[$urandom_range(0, 3)];
          else               v = '0;
        end while (v == prevv);
        if (sel < 55 && cur < 3) cur++;
        it.v = v; it.hold = $urandom_range(1, 5);
        items.push_back(it);
        prevv = v;
      end
      settle_zero(); pulse_start();
      foreach (items[j]) drive(items[j].v, items[j].hold);
      repeat (S + 5) tick();
      model_run(strict, e_done, e_pass, e_fr, e_stage, e_last);
      chk($sformatf("rnd%0d_done", r), 32'(done), 32'(e_done));
      chk($sformatf("rnd%0d_pass", r), 32'(pass), 32'(e_pass));
      chk($sformatf("rnd%0d_busy", r), 32'(busy), 32'(!e_done));
      chk($sformatf("rnd%0d_reason", r), 32'(fail_reason), 32'(e_fr));
      chk($sformatf("rnd%0d_stage", r), 32'(stage), 32'(e_stage));
      chk($sformatf("rnd%0d_last", r), 32'(last_code), 32'(e_last));
      pulse_abort();
    end

    // Single-stage 32-bit build: timeout edge vs first accept
    strict_b = 1'b1;
    cfg_we_b = 1'b1; cfg_idx_b = '0; cfg_code_b = 32'hDEADBEEF; tick(); cfg_we_b = 1'b0;
    checkbits_b = '0; repeat (8) tick();
    tmo_limit_b = 24'd3;
    start_b = 1'b1; checkbits_b = 32'hDEADBEEF; tick(); start_b = 1'b0;
    repeat (8) tick();
    chk("b_early_tmo_done", 32'(done_b), 1);
    chk("b_early_tmo_reason", 32'(fail_reason_b), 1);
    checkbits_b = '0; repeat (8) tick();
    tmo_limit_b = 24'd4;
    start_b = 1'b1; checkbits_b = 32'hDEADBEEF; tick(); start_b = 1'b0;
    repeat (8) tick();
    chk("b_tie_pass", 32'(pass_b), 1);
    chk("b_tie_reason", 32'(fail_reason_b), 0);
    chk("b_tie_stage", 32'(stage_b), 0);
    chk("b_tie_last", last_code_b, 32'hDEADBEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/checkpoint_seq_monitor.md
CHECKPOINT_SEQ_MONITOR -- requirements
Module: checkpoint_seq_monitor

Interface
REQ-001 Parameter CHECK_W, default 16: width of the monitored checkpoint bus.
REQ-002 Parameter NUM_STAGES, default 4, range 1..16: number of expected codes in the sequence.
REQ-003 Parameter STABLE_CYCLES, default 2, minimum 1: consecutive synchronised cycles a value must hold before it is accepted.
REQ-004 Parameter TMO_W, default 24: width of the per-stage timeout counter and limit.
REQ-005 clock  in  1  single block clock, all state on rising edge.
REQ-006 resetb  in  1  reset, asynchronous assert, active-low.
REQ-007 checkbits  in  CHECK_W  asynchronous checkpoint bus, e.g. GPIO-sourced.
REQ-008 cfg_we  in  1  write-enable for the expected-code table.
REQ-009 cfg_idx  in  clog2(NUM_STAGES), minimum 1  table index.
REQ-010 cfg_code  in  CHECK_W  expected code written at cfg_idx.
REQ-011 tmo_limit  in  TMO_W  per-stage timeout in cycles; 0 disables the timeout.
REQ-012 strict  in  1  1 = any unexpected stable nonzero code fails the run.
REQ-013 start  in  1  single-cycle pulse that arms a run.
REQ-014 abort  in  1  single-cycle pulse that returns the block to IDLE.
REQ-015 busy  out  1  high in WAIT_FIRST or TRACK.
REQ-016 done  out  1  high in PASS or FAIL.
REQ-017 pass  out  1  high in PASS.
REQ-018 fail_reason  out  2  00 none, 01 timeout, 10 illegal code.
REQ-019 stage  out  clog2(NUM_STAGES), minimum 1  index of the currently expected code.
REQ-020 last_code  out  CHECK_W  most recently accepted stable value.

Function
REQ-021 checkbits SHALL pass through a 2-flop synchroniser; all logic uses the synchronised value.
REQ-022 A stability filter SHALL accept a value only after it has been unchanged for STABLE_CYCLES synchronised cycles, producing one accept pulse per distinct stable value.
REQ-023 FSM states: IDLE, WAIT_FIRST, TRACK, PASS, FAIL.
REQ-024 IDLE: start moves to WAIT_FIRST; stage cleared, fail_reason cleared, timeout counter cleared.
REQ-025 WAIT_FIRST: the first accepted nonzero value moves to TRACK and is evaluated in that same cycle, as in TRACK; accepted zero is ignored.
REQ-026 TRACK, accept of code[stage]: if stage == NUM_STAGES-1, go to PASS; otherwise stage increments and the timeout counter clears.
REQ-027 TRACK, accept of a nonzero value that is not code[stage] and not last_code: strict=1 goes to FAIL with reason 10; strict=0 ignores it.
REQ-028 Timeout counter SHALL run in WAIT_FIRST and TRACK when tmo_limit != 0, and SHALL saturate, never wrap.
REQ-029 Timeout: counter == tmo_limit-1 with no advancing accept that cycle goes to FAIL with reason 01.
REQ-030 Timeout and an advancing accept in the same cycle: the accept wins.
REQ-031 PASS/FAIL: states are held, and outputs are held, until start (new run) or abort.
REQ-032 abort SHALL go to IDLE from any state and takes priority over start and over every other event in that cycle.
REQ-033 cfg_we SHALL update the table in any state; a write to the current stage takes effect for the next compare cycle.
REQ-034 Latency: a checkbits change reaches the FSM 2 + STABLE_CYCLES cycles later; done asserts in the following cycle.

Reset
REQ-035 On resetb low: FSM = IDLE, synchroniser and filter = 0, stage = 0, last_code = 0, timeout counter = 0; all table entries = 0.
REQ-036 Reset values: busy/done/pass = 0, fail_reason = 00.
REQ-037 Reset deassertion mid-run SHALL leave the block in IDLE; no run resumes.

Structure
REQ-038 A shared package checkpoint_pkg SHALL hold the FSM state enum, the fail_reason encodings and the default parameter constants.
REQ-039 The synchroniser plus stability filter SHALL be one sub-module, checkpoint_stable_filter, parametrised by CHECK_W and STABLE_CYCLES.

Verification
REQ-040 Table {AB60,AB61,AB62,AB63}, strict=1, tmo_limit=1000; drive the codes in order, each held 5 cycles -> pass=1, stage=3, last_code=AB63.
REQ-041 strict=1, after AB60 drive 1234 for 5 cycles -> FAIL, fail_reason=10, last_code=1234; the same stimulus with strict=0 -> run continues to PASS.
REQ-042 tmo_limit=50, hold AB60 only -> FAIL, reason=01, exactly 50 cycles after the AB60 accept; tmo_limit=0 -> busy held high indefinitely.
REQ-043 STABLE_CYCLES=2, AB61 glitch of 1 synchronised cycle -> not accepted, stage unchanged.
REQ-044 start and abort in the same cycle -> IDLE; resetb asserted mid-TRACK -> all outputs at reset values asynchronously.
REQ-045 NUM_STAGES=1, CHECK_W=32 build, code DEADBEEF -> PASS on first accept; reaching timeout and accepting in the same cycle -> PASS.
